// File: rtl/alu_b_fwd_ctrl_pkg.sv
// Shared encodings and the shadow-stage record for the ALU B-operand
// select/forwarding controller.
package alu_b_fwd_ctrl_pkg;

  typedef enum logic [2:0] {
    B_SEL_REG       = 3'b000,
    B_SEL_IMM       = 3'b001,
    B_SEL_FWD_EXMEM = 3'b010,
    B_SEL_FWD_MEMWB = 3'b011,
    B_SEL_CONST     = 3'b100,
    B_SEL_ZERO      = 3'b101
  } b_sel_e;

  localparam logic [1:0] SRC_REG   = 2'b00;
  localparam logic [1:0] SRC_IMM   = 2'b01;
  localparam logic [1:0] SRC_CONST = 2'b10;
  localparam logic [1:0] SRC_ZERO  = 2'b11;

  // Shadow register field is sized for the largest supported register file;
  // narrower specifiers are zero-extended into it.
  localparam int SHD_REG_W = 8;

  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic [SHD_REG_W-1:0] wr_reg;
    logic                 is_load;
  } shadow_t;

endpackage

// File: rtl/alu_b_fwd_ctrl_shadow.sv
// One pipeline-stage copy of destination-register info; loads a bubble
// whenever the load enable is low.
module alu_b_shadow_stage
  import alu_b_fwd_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_load,
  input  shadow_t i_d,
  output shadow_t o_q
);

  shadow_t r_q;

  always_ff @(posedge clk) begin
    if (rst)         r_q <= '0;
    else if (i_load) r_q <= i_d;
    else             r_q <= '0;
  end

  assign o_q = r_q;

endmodule

// File: rtl/alu_b_fwd_ctrl.sv
// ALU B-operand select/forwarding controller: picks the B source at decode,
// registers it into EX, and stalls one cycle on load-use hazards.
module alu_b_fwd_ctrl
  import alu_b_fwd_ctrl_pkg::*;
#(
  parameter int REG_BITS = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [1:0]          id_b_src,
  input  logic                id_wr_en,
  input  logic [REG_BITS-1:0] id_wr_reg,
  input  logic                id_is_load,
  input  logic                flush,
  output logic [2:0]          ex_b_sel,
  output logic                ex_valid,
  output logic                stall,
  output logic [CNT_W-1:0]    stall_cnt
);

  shadow_t w_ex, w_mem, w_id;
  logic [SHD_REG_W-1:0] w_rt;
  logic w_ex_hit, w_mem_hit, w_issue;
  b_sel_e w_sel;
  logic [2:0] r_ex_b_sel;
  logic [CNT_W-1:0] r_cnt;

  assign w_rt = SHD_REG_W'(id_rt);
  assign w_id = '{valid: 1'b1, wr_en: id_wr_en,
                  wr_reg: SHD_REG_W'(id_wr_reg), is_load: id_is_load};

  assign w_ex_hit  = w_ex.valid  & w_ex.wr_en  & (w_ex.wr_reg  == w_rt);
  assign w_mem_hit = w_mem.valid & w_mem.wr_en & (w_mem.wr_reg == w_rt);

  assign stall   = id_valid & ~flush & (id_b_src == SRC_REG) & w_ex_hit & w_ex.is_load;
  assign w_issue = id_valid & ~stall & ~flush;

  // EX producer wins over MEM: it is the younger write to the same register.
  always_comb begin
    w_sel = B_SEL_REG;
    case (id_b_src)
      SRC_IMM:   w_sel = B_SEL_IMM;
      SRC_CONST: w_sel = B_SEL_CONST;
      SRC_ZERO:  w_sel = B_SEL_ZERO;
      default: begin
        if (w_ex_hit && !w_ex.is_load) w_sel = B_SEL_FWD_EXMEM;
        else if (w_mem_hit)            w_sel = B_SEL_FWD_MEMWB;
        else                           w_sel = B_SEL_REG;
      end
    endcase
  end

  alu_b_shadow_stage u_ex (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_issue),
    .i_d    (w_id),
    .o_q    (w_ex)
  );

  alu_b_shadow_stage u_mem (
    .clk    (clk),
    .rst    (rst),
    .i_load (1'b1),
    .i_d    (w_ex),
    .o_q    (w_mem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_b_sel <= B_SEL_ZERO;
      r_cnt      <= '0;
    end else begin
      r_ex_b_sel <= w_issue ? w_sel : B_SEL_ZERO;
      if (stall && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ex_b_sel  = r_ex_b_sel;
  assign ex_valid  = w_ex.valid;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_alu_b_fwd_ctrl.sv
// Directed bench for alu_b_fwd_ctrl: forwarding selects, load-use stall,
// flush, counter saturation and reset mid-stall.
module tb_alu_b_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rt;
  logic [1:0] id_b_src;
  logic       id_wr_en;
  logic [2:0] id_wr_reg;
  logic       id_is_load;
  logic       flush;
  logic [2:0] ex_b_sel;
  logic       ex_valid;
  logic       stall;
  logic [3:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  alu_b_fwd_ctrl #(.REG_BITS(3), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rt      (id_rt),
    .id_b_src   (id_b_src),
    .id_wr_en   (id_wr_en),
    .id_wr_reg  (id_wr_reg),
    .id_is_load (id_is_load),
    .flush      (flush),
    .ex_b_sel   (ex_b_sel),
    .ex_valid   (ex_valid),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a valid decode instruction; settle combinational outputs.
  task automatic ins(input logic [1:0] src, input logic [2:0] rt,
                     input logic wen, input logic [2:0] wreg, input logic ld);
    id_valid = 1'b1; id_b_src = src; id_rt = rt;
    id_wr_en = wen; id_wr_reg = wreg; id_is_load = ld; flush = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    ins(2'b00, 3'd1, 1'b1, 3'd1, 1'b0);
    tick(); tick();
    chk("rst_sel",   32'(ex_b_sel),  32'd5);
    chk("rst_valid", 32'(ex_valid),  32'd0);
    chk("rst_stall", 32'(stall),     32'd0);
    chk("rst_cnt",   32'(stall_cnt), 32'd0);
    rst = 1'b0;

    // back-to-back ALU forward
    ins(2'b01, 3'd0, 1'b1, 3'd1, 1'b0); tick();
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_sel",   32'(ex_b_sel), 32'd1);
    ins(2'b00, 3'd1, 1'b1, 3'd4, 1'b0);
    chk("b2b_nostall", 32'(stall), 32'd0);
    tick();
    chk("b2b_sel", 32'(ex_b_sel), 32'd2);

    // separated by one
    ins(2'b10, 3'd0, 1'b1, 3'd1, 1'b0); tick();
    chk("const_sel", 32'(ex_b_sel), 32'd4);
    ins(2'b11, 3'd0, 1'b0, 3'd0, 1'b0); tick();
    chk("zero_sel", 32'(ex_b_sel), 32'd5);
    chk("zero_valid", 32'(ex_valid), 32'd1);
    ins(2'b00, 3'd1, 1'b0, 3'd0, 1'b0); tick();
    chk("sep1_sel", 32'(ex_b_sel), 32'd3);

    // separated by two
    ins(2'b01, 3'd0, 1'b1, 3'd1, 1'b0); tick();
    ins(2'b11, 3'd0, 1'b0, 3'd0, 1'b0); tick();
    ins(2'b11, 3'd0, 1'b0, 3'd0, 1'b0); tick();
    ins(2'b00, 3'd1, 1'b0, 3'd0, 1'b0); tick();
    chk("sep2_sel", 32'(ex_b_sel), 32'd0);

    // load-use
    ins(2'b01, 3'd0, 1'b1, 3'd2, 1'b1); tick();
    ins(2'b00, 3'd2, 1'b0, 3'd0, 1'b0);
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_bub_valid", 32'(ex_valid),  32'd0);
    chk("lu_bub_sel",   32'(ex_b_sel),  32'd5);
    chk("lu_cnt",       32'(stall_cnt), 32'd1);
    chk("lu_stall_end", 32'(stall),     32'd0);
    tick();
    chk("lu_sel",   32'(ex_b_sel), 32'd3);
    chk("lu_valid", 32'(ex_valid), 32'd1);

    // priority: EX beats MEM
    ins(2'b01, 3'd0, 1'b1, 3'd3, 1'b0); tick();
    ins(2'b01, 3'd0, 1'b1, 3'd3, 1'b0); tick();
    ins(2'b00, 3'd3, 1'b0, 3'd0, 1'b0); tick();
    chk("prio_sel", 32'(ex_b_sel), 32'd2);

    // immediate source ignores pending load
    ins(2'b01, 3'd0, 1'b1, 3'd6, 1'b1); tick();
    ins(2'b01, 3'd6, 1'b0, 3'd0, 1'b0);
    chk("imm_nostall", 32'(stall), 32'd0);
    tick();
    chk("imm_sel", 32'(ex_b_sel), 32'd1);
    chk("imm_cnt", 32'(stall_cnt), 32'd1);

    // flush during load-use
    ins(2'b01, 3'd0, 1'b1, 3'd7, 1'b1); tick();
    ins(2'b00, 3'd7, 1'b0, 3'd0, 1'b0);
    flush = 1'b1; #1;
    chk("fl_stall", 32'(stall), 32'd0);
    tick();
    chk("fl_valid", 32'(ex_valid),  32'd0);
    chk("fl_sel",   32'(ex_b_sel),  32'd5);
    chk("fl_cnt",   32'(stall_cnt), 32'd1);
    flush = 1'b0;

    // 16 more load-use stalls: 17 total saturates a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      ins(2'b01, 3'd0, 1'b1, 3'd2, 1'b1); tick();
      ins(2'b00, 3'd2, 1'b0, 3'd0, 1'b0); tick();
      tick();
      if (i == 13) chk("cnt_15", 32'(stall_cnt), 32'd15);
    end
    chk("cnt_sat", 32'(stall_cnt), 32'd15);

    // reset in the middle of a stall drops the held consumer
    ins(2'b01, 3'd0, 1'b1, 3'd2, 1'b1); tick();
    ins(2'b00, 3'd2, 1'b0, 3'd0, 1'b0);
    chk("mid_stall", 32'(stall), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    id_valid = 1'b0; #1;
    chk("mid_rst_stall", 32'(stall),     32'd0);
    chk("mid_rst_valid", 32'(ex_valid),  32'd0);
    chk("mid_rst_cnt",   32'(stall_cnt), 32'd0);
    tick();
    chk("idle_bubble", 32'(ex_b_sel), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
